// File: rtl/inst_encoder.sv
// Packs ALU/immediate requests into 32-bit MIPS words and buffers them in a FIFO
// that drains to instruction memory with an auto-incrementing byte address.
module inst_encoder #(
    parameter int          DEPTH      = 4,
    parameter int          ADDR_W     = 8,
    parameter logic [5:0]  IMM_OPCODE = 6'b100011
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_imm,
    input  logic [2:0]                 req_alu_op,
    input  logic [4:0]                 req_shamt,
    input  logic [4:0]                 req_rs,
    input  logic [4:0]                 req_rt,
    input  logic [4:0]                 req_rd,
    input  logic [15:0]                req_imm16,
    output logic [31:0]                inst_out,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [ADDR_W-1:0]          inst_addr,
    output logic                       enc_err,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

    state_t                 state, state_nxt;
    logic [DEPTH-1:0][31:0] mem;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic                   accept, pop, push, illegal;
    logic [5:0]             funct;
    logic                   is_shift;
    logic [31:0]            enc_word;

    assign req_ready  = (state != FULL);
    assign inst_valid = (state != EMPTY);
    assign accept     = req_valid & req_ready;
    assign pop        = inst_valid & inst_ready;
    assign illegal    = !req_imm && (req_alu_op == 3'd0 || req_alu_op == 3'd7);
    assign push       = accept & !illegal;
    assign is_shift   = (req_alu_op == 3'd5) || (req_alu_op == 3'd6);

    always_comb begin
        funct = 6'b000000;
        case (req_alu_op)
            3'd1:    funct = 6'b100000;
            3'd2:    funct = 6'b100010;
            3'd3:    funct = 6'b100100;
            3'd4:    funct = 6'b100101;
            3'd5:    funct = 6'b000000;
            3'd6:    funct = 6'b000010;
            default: funct = 6'b000000;
        endcase
    end

    // Shifts carry the amount in shamt and leave rs zero so the decoder sees a clean sll/srl.
    always_comb begin
        if (req_imm)
            enc_word = {IMM_OPCODE, req_rs, req_rt, req_imm16};
        else
            enc_word = {6'b000000, (is_shift ? 5'd0 : req_rs), req_rt, req_rd,
                        (is_shift ? req_shamt : 5'd0), funct};
    end

    assign inst_out = inst_valid ? mem[rd_ptr] : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (push) state_nxt = PARTIAL;
            PARTIAL: begin
                if (push && !pop && count == CW'(DEPTH - 1))
                    state_nxt = FULL;
                else if (pop && !push && count == CW'(1))
                    state_nxt = EMPTY;
            end
            FULL:    if (pop) state_nxt = PARTIAL;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            inst_addr <= '0;
            enc_err   <= 1'b0;
        end else begin
            enc_err <= accept & illegal;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + PW'(1);
                inst_addr <= inst_addr + ADDR_W'(4);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: inst_out is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enc_word;
    end
endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: encodings, decoder round trip, backpressure,
// illegal ops and asynchronous reset mid-stream.
module tb_inst_encoder;
    logic        clk, rst_n;
    logic        req_valid, req_ready, req_imm;
    logic [2:0]  req_alu_op;
    logic [4:0]  req_shamt, req_rs, req_rt, req_rd;
    logic [15:0] req_imm16;
    logic [31:0] inst_out;
    logic        inst_valid, inst_ready;
    logic [7:0]  inst_addr;
    logic        enc_err;
    logic [2:0]  count;

    int vectors = 0;
    int miscompares = 0;

    inst_encoder dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_imm(req_imm),
        .req_alu_op(req_alu_op), .req_shamt(req_shamt), .req_rs(req_rs),
        .req_rt(req_rt), .req_rd(req_rd), .req_imm16(req_imm16),
        .inst_out(inst_out), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_addr(inst_addr), .enc_err(enc_err), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Control-unit decoder model: {alu_op, shamt} for R-type, alu_op 0 for immediate.
    function automatic logic [7:0] dec_aluop_shamt(input logic [31:0] w);
        logic [2:0] op;
        if (w[31]) return 8'h00;
        case (w[5:0])
            6'b100000: op = 3'd1;
            6'b100010: op = 3'd2;
            6'b100100: op = 3'd3;
            6'b100101: op = 3'd4;
            6'b000000: op = 3'd5;
            6'b000010: op = 3'd6;
            default:   op = 3'd0;
        endcase
        return {op, w[10:6]};
    endfunction

    task automatic set_r(input logic [2:0] op, input logic [4:0] sh,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        req_imm = 1'b0; req_alu_op = op; req_shamt = sh;
        req_rs = rs; req_rt = rt; req_rd = rd; req_imm16 = 16'h0;
    endtask

    task automatic set_i(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        req_imm = 1'b1; req_alu_op = 3'd0; req_shamt = 5'd0;
        req_rs = rs; req_rt = rt; req_rd = 5'd0; req_imm16 = imm;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_addr", 32'(inst_addr), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; inst_ready = 1'b0;
        set_r(3'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        @(negedge clk); @(negedge clk);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_inst_valid", 32'(inst_valid), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_inst_out", inst_out, 32'd0);
        chk("reset_addr", 32'(inst_addr), 32'd0);
        chk("reset_enc_err", 32'(enc_err), 32'd0);
        rst_n = 1'b1;

        // 1: add
        @(negedge clk);
        inst_ready = 1'b1;
        set_r(3'd1, 5'd0, 5'd1, 5'd2, 5'd3); req_valid = 1'b1;
        @(negedge clk); req_valid = 1'b0;
        chk("add_word", inst_out, 32'h00221820);
        chk("add_addr", 32'(inst_addr), 32'd0);
        chk("add_valid", 32'(inst_valid), 32'd1);
        chk("add_dec", 32'(dec_aluop_shamt(inst_out)), 32'h20);
        @(negedge clk);
        chk("add_addr_post", 32'(inst_addr), 32'd4);
        chk("add_drained", 32'(inst_valid), 32'd0);

        // 2: sll
        set_r(3'd5, 5'd3, 5'd7, 5'd4, 5'd5); req_valid = 1'b1;
        @(negedge clk); req_valid = 1'b0;
        chk("sll_word", inst_out, 32'h000428C0);
        chk("sll_dec", 32'(dec_aluop_shamt(inst_out)), 32'hA3);
        chk("sll_addr", 32'(inst_addr), 32'd4);
        @(negedge clk);

        // 3: immediate
        set_i(5'd2, 5'd9, 16'h0010); req_valid = 1'b1;
        @(negedge clk); req_valid = 1'b0;
        chk("imm_word", inst_out, 32'h8C490010);
        chk("imm_mux_cont", 32'(inst_out[31]), 32'd1);
        chk("imm_dec_aluop", 32'(dec_aluop_shamt(inst_out)), 32'h00);
        chk("imm_addr", 32'(inst_addr), 32'd8);
        @(negedge clk);
        chk("imm_addr_post", 32'(inst_addr), 32'd12);

        // 4: full / backpressure, fresh address base
        pulse_reset();
        @(negedge clk);
        inst_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            set_r(3'd1, 5'd0, 5'(k), 5'd2, 5'd3); req_valid = 1'b1;
            @(negedge clk);
        end
        set_r(3'd1, 5'd0, 5'd5, 5'd2, 5'd3);
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(req_ready), 32'd0);
        chk("full_head", inst_out, 32'h00221820);
        @(negedge clk);
        chk("full_count_hold", 32'(count), 32'd4);
        chk("full_head_hold", inst_out, 32'h00221820);
        chk("full_addr_hold", 32'(inst_addr), 32'd0);
        req_valid = 1'b0;
        inst_ready = 1'b1;
        chk("drain0_word", inst_out, 32'h00221820);
        chk("drain0_addr", 32'(inst_addr), 32'd0);
        @(negedge clk);
        chk("drain1_word", inst_out, 32'h00421820);
        chk("drain1_addr", 32'(inst_addr), 32'd4);
        chk("drain1_count", 32'(count), 32'd3);
        @(negedge clk);
        chk("drain2_word", inst_out, 32'h00621820);
        chk("drain2_addr", 32'(inst_addr), 32'd8);
        @(negedge clk);
        chk("drain3_word", inst_out, 32'h00821820);
        chk("drain3_addr", 32'(inst_addr), 32'd12);
        @(negedge clk);
        chk("drain_empty", 32'(inst_valid), 32'd0);
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_addr", 32'(inst_addr), 32'd16);
        chk("drain_out_zero", inst_out, 32'd0);

        // 5: illegal ops
        set_r(3'd7, 5'd0, 5'd1, 5'd2, 5'd3); req_valid = 1'b1;
        chk("ill_ready", 32'(req_ready), 32'd1);
        @(negedge clk); req_valid = 1'b0;
        chk("ill7_err", 32'(enc_err), 32'd1);
        chk("ill7_count", 32'(count), 32'd0);
        chk("ill7_valid", 32'(inst_valid), 32'd0);
        @(negedge clk);
        chk("ill7_err_clear", 32'(enc_err), 32'd0);
        set_r(3'd0, 5'd0, 5'd1, 5'd2, 5'd3); req_valid = 1'b1;
        @(negedge clk); req_valid = 1'b0;
        chk("ill0_err", 32'(enc_err), 32'd1);
        chk("ill0_count", 32'(count), 32'd0);
        @(negedge clk);
        chk("ill0_err_clear", 32'(enc_err), 32'd0);

        // 6: reset mid-operation
        inst_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            set_r(3'd2, 5'd0, 5'd1, 5'(k), 5'd4); req_valid = 1'b1;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("mid_count", 32'(count), 32'd3);
        pulse_reset();
        @(negedge clk);
        // streaming push+pop after reset: sub then or
        inst_ready = 1'b1;
        set_r(3'd2, 5'd0, 5'd1, 5'd2, 5'd3); req_valid = 1'b1;
        @(negedge clk);
        chk("post_sub_word", inst_out, 32'h00221822);
        chk("post_sub_addr", 32'(inst_addr), 32'd0);
        chk("post_count1", 32'(count), 32'd1);
        set_r(3'd4, 5'd0, 5'd1, 5'd2, 5'd3);
        @(negedge clk); req_valid = 1'b0;
        chk("post_or_word", inst_out, 32'h00221825);
        chk("post_or_addr", 32'(inst_addr), 32'd4);
        chk("post_pushpop_count", 32'(count), 32'd1);
        @(negedge clk);
        chk("post_final_count", 32'(count), 32'd0);
        chk("post_final_addr", 32'(inst_addr), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
